sa_pe_mp: RTL and testbench

//  Weight-stationary systolic-array PE, next generation: parametrised width, three precision modes,

---
 rtl/sa_pe_mp_pkg.sv | 25 ++
 rtl/sa_pe_mp_mult.sv | 55 +++++
 rtl/sa_pe_mp.sv | 186 ++++++++++++++++++
 tb/tb_sa_pe_mp.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pe_mp_pkg.sv
// Shared types and defaults for the multi-precision systolic PE.
// Ports: none (package). Defines the precision mode enum, default widths and a lane-count helper.
// Imported by sa_pe_mp and sa_pe_mp_mult.
package sa_pe_mp_pkg;

  typedef enum logic [1:0] {
    PE_FULL    = 2'b00,  // one DATA_W x DATA_W product
    PE_HALF    = 2'b01,  // two DATA_W/2 lanes
    PE_QUARTER = 2'b10,  // four DATA_W/4 lanes
    PE_RSVD    = 2'b11   // illegal, handled as FULL
  } pe_mode_t;

  localparam int PE_DATA_W_DEF = 8;
  localparam int PE_ACC_W_DEF  = 20;
  localparam int PE_MAX_LANES  = 4;

  function automatic int unsigned pe_lane_count(input pe_mode_t m);
    case (m)
      PE_HALF:    return 2;
      PE_QUARTER: return 4;
      default:    return 1;
    endcase
  endfunction

endpackage

// File: rtl/sa_pe_mp_mult.sv
// Combinational multi-precision lane multiplier: x and w split into 1/2/4 lanes, one product per lane.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Ports: x, w (DATA_W operands), mode, is_signed in; prod (4 lanes, each 2*DATA_W, already
// sign/zero-extended to 2*DATA_W, unused lanes zero) out.
module sa_pe_mp_mult
  import sa_pe_mp_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W_DEF
) (
  input  logic [DATA_W-1:0]                      x,
  input  logic [DATA_W-1:0]                      w,
  input  pe_mode_t                               mode,
  input  logic                                   is_signed,
  output logic [PE_MAX_LANES-1:0][2*DATA_W-1:0]  prod
);

  localparam int P = 2 * DATA_W;
  localparam int H = DATA_W / 2;
  localparam int Q = DATA_W / 4;

  // Both operands are extended to the full product width first; a P x P multiply truncated
  // to P bits is then the exact lane product, already extended to P bits.
  function automatic logic [P-1:0] ext_f(input logic [DATA_W-1:0] v, input logic s);
    return {{(P-DATA_W){s & v[DATA_W-1]}}, v};
  endfunction

  function automatic logic [P-1:0] ext_h(input logic [H-1:0] v, input logic s);
    return {{(P-H){s & v[H-1]}}, v};
  endfunction

  function automatic logic [P-1:0] ext_q(input logic [Q-1:0] v, input logic s);
    return {{(P-Q){s & v[Q-1]}}, v};
  endfunction

  always_comb begin
    prod = '0;
    case (mode)
      PE_HALF: begin
        for (int i = 0; i < 2; i++) begin
          prod[i] = ext_h(x[i*H +: H], is_signed) * ext_h(w[i*H +: H], is_signed);
        end
      end
      PE_QUARTER: begin
        for (int i = 0; i < 4; i++) begin
          prod[i] = ext_q(x[i*Q +: Q], is_signed) * ext_q(w[i*Q +: Q], is_signed);
        end
      end
      default: begin
        // FULL, and the reserved encoding which falls back to FULL
        prod[0] = ext_f(x, is_signed) * ext_f(w, is_signed);
      end
    endcase
  end

endmodule

// File: rtl/sa_pe_mp.sv
// Weight-stationary systolic PE: double-buffered weight, 1/2/4-lane dot product added to the column partial sum.
// Latency: out_right 1 cycle, out_bot 2 cycles after in_left_valid. Backpressure: en=0 stalls every register.
// Ports: clk, reset (async active-low), en, mode, is_signed, w_load, w_swap, in_left(_valid), in_top(_valid) in;
// out_right(_valid), out_bot(_valid) out; sat_flag out only when PE_SATURATE_EN is defined (clamping sum).
module sa_pe_mp
  import sa_pe_mp_pkg::*;
#(
  parameter int DATA_W = PE_DATA_W_DEF,
  parameter int ACC_W  = PE_ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              is_signed,
  input  logic              w_load,
  input  logic              w_swap,
  input  logic              in_left_valid,
  input  logic [DATA_W-1:0] in_left,
  input  logic              in_top_valid,
  input  logic [ACC_W-1:0]  in_top,
  output logic              out_right_valid,
  output logic [DATA_W-1:0] out_right,
  output logic              out_bot_valid,
`ifdef PE_SATURATE_EN
  output logic [ACC_W-1:0]  out_bot,
  output logic              sat_flag
`else
  output logic [ACC_W-1:0]  out_bot
`endif
);

  localparam int P     = 2 * DATA_W;
  localparam int LANES = PE_MAX_LANES;
`ifdef PE_SATURATE_EN
  // Three guard bits hold the exact sum of the partial sum plus four lane products.
  localparam int SUM_W = ACC_W + 3;
`else
  localparam int SUM_W = ACC_W;
`endif

  // Horizontal pass-through
  logic              out_right_valid_q, out_right_valid_d;
  logic [DATA_W-1:0] out_right_q, out_right_d;
  // Weight double buffer
  logic [DATA_W-1:0] shadow_w_q, shadow_w_d;
  logic [DATA_W-1:0] active_w_q, active_w_d;
  // Stage 1: lane products already reflect the mode of their own capture edge, so only
  // the signedness has to travel with them for the final extension.
  logic                           v1_q, v1_d;
  logic                           sgn1_q, sgn1_d;
  logic [LANES-1:0][P-1:0]        prod_q, prod_d;
  logic [ACC_W-1:0]               top_q, top_d;
  // Stage 2
  logic              out_bot_valid_q, out_bot_valid_d;
  logic [ACC_W-1:0]  out_bot_q, out_bot_d;
`ifdef PE_SATURATE_EN
  logic              sat_flag_q, sat_flag_d;
`endif

  logic [LANES-1:0][P-1:0] prod_c;
  logic [SUM_W-1:0]        sum_c;
  logic [ACC_W-1:0]        res_c;
  logic                    ovf_c;

  sa_pe_mp_mult #(
    .DATA_W (DATA_W)
  ) u_mult (
    .x         (in_left),
    .w         (active_w_q),
    .mode      (pe_mode_t'(mode)),
    .is_signed (is_signed),
    .prod      (prod_c)
  );

  // Partial sum plus every lane product, each extended by the captured signedness.
  always_comb begin
    sum_c = SUM_W'($signed({sgn1_q & top_q[ACC_W-1], top_q}));
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SUM_W'($signed({sgn1_q & prod_q[i][P-1], prod_q[i]}));
    end
  end

`ifdef PE_SATURATE_EN
  logic [SUM_W-ACC_W:0] hi_c;
  always_comb begin
    hi_c  = sum_c[SUM_W-1:ACC_W-1];
    res_c = sum_c[ACC_W-1:0];
    ovf_c = 1'b0;
    if (sgn1_q) begin
      // Signed result fits only if the guard bits all equal the ACC_W sign bit.
      if (!(hi_c == '0 || hi_c == '1)) begin
        ovf_c = 1'b1;
        res_c = sum_c[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (hi_c[SUM_W-ACC_W:1] != '0) begin
      ovf_c = 1'b1;
      res_c = '1;
    end
  end
`else
  assign res_c = sum_c;
  assign ovf_c = 1'b0;
`endif

  always_comb begin
    out_right_valid_d = out_right_valid_q;
    out_right_d       = out_right_q;
    shadow_w_d        = shadow_w_q;
    active_w_d        = active_w_q;
    v1_d              = v1_q;
    sgn1_d            = sgn1_q;
    prod_d            = prod_q;
    top_d             = top_q;
    out_bot_valid_d   = out_bot_valid_q;
    out_bot_d         = out_bot_q;
`ifdef PE_SATURATE_EN
    sat_flag_d        = sat_flag_q;
`endif
    if (en) begin
      out_right_valid_d = in_left_valid;
      out_right_d       = in_left;
      // Swap takes the shadow value from before this edge, so a same-cycle load is not visible yet.
      if (w_load) shadow_w_d = in_left;
      if (w_swap) active_w_d = shadow_w_q;
      // A weight-load beat is not an activation for this PE.
      v1_d = in_left_valid & ~w_load;
      if (v1_d) begin
        prod_d = prod_c;
        sgn1_d = is_signed;
        top_d  = in_top_valid ? in_top : '0;
      end
      out_bot_valid_d = v1_q;
      out_bot_d       = v1_q ? res_c : '0;
`ifdef PE_SATURATE_EN
      sat_flag_d      = v1_q & ovf_c;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_right_valid_q <= 1'b0;
      out_right_q       <= '0;
      shadow_w_q        <= '0;
      active_w_q        <= '0;
      v1_q              <= 1'b0;
      sgn1_q            <= 1'b0;
      prod_q            <= '0;
      top_q             <= '0;
      out_bot_valid_q   <= 1'b0;
      out_bot_q         <= '0;
`ifdef PE_SATURATE_EN
      sat_flag_q        <= 1'b0;
`endif
    end else begin
      out_right_valid_q <= out_right_valid_d;
      out_right_q       <= out_right_d;
      shadow_w_q        <= shadow_w_d;
      active_w_q        <= active_w_d;
      v1_q              <= v1_d;
      sgn1_q            <= sgn1_d;
      prod_q            <= prod_d;
      top_q             <= top_d;
      out_bot_valid_q   <= out_bot_valid_d;
      out_bot_q         <= out_bot_d;
`ifdef PE_SATURATE_EN
      sat_flag_q        <= sat_flag_d;
`endif
    end
  end

  assign out_right_valid = out_right_valid_q;
  assign out_right       = out_right_q;
  assign out_bot_valid   = out_bot_valid_q;
  assign out_bot         = out_bot_q;
`ifdef PE_SATURATE_EN
  assign sat_flag        = sat_flag_q;
`endif

  // The reserved mode encoding computes as FULL but flags the misuse whenever it reaches the multiplier.
  a_mode_legal : assert property (@(posedge clk) disable iff (!reset)
                                  !(en && in_left_valid && mode == 2'b11))
    else $error("sa_pe_mp: reserved mode 2'b11 used");

endmodule

// File: tb/tb_sa_pe_mp.sv
module tb_sa_pe_mp;

  typedef struct packed {logic v; logic [7:0] d;} rt_t;
  typedef struct packed {logic v; logic [19:0] d; logic sat;} bt_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        is_signed = 1'b0;
  logic        w_load = 1'b0;
  logic        w_swap = 1'b0;
  logic        in_left_valid = 1'b0;
  logic [7:0]  in_left = '0;
  logic        in_top_valid = 1'b0;
  logic [19:0] in_top = '0;
  logic        out_right_valid;
  logic [7:0]  out_right;
  logic        out_bot_valid;
  logic [19:0] out_bot;
  logic        sat_flag;

  int checks = 0;
  int errors = 0;

  rt_t right_q[$];
  bt_t bot_q[$];
  logic [7:0] m_active = '0;
  logic [7:0] m_shadow = '0;

  logic        new_edge = 1'b0;
  logic        stall_edge = 1'b0;
  logic        last_rv = 1'b0, last_bv = 1'b0, last_sat = 1'b0;
  logic [7:0]  last_r = '0;
  logic [19:0] last_b = '0;

  sa_pe_mp #(.DATA_W(8), .ACC_W(20)) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .mode            (mode),
    .is_signed       (is_signed),
    .w_load          (w_load),
    .w_swap          (w_swap),
    .in_left_valid   (in_left_valid),
    .in_left         (in_left),
    .in_top_valid    (in_top_valid),
    .in_top          (in_top),
    .out_right_valid (out_right_valid),
    .out_right       (out_right),
    .out_bot_valid   (out_bot_valid),
`ifdef PE_SATURATE_EN
    .out_bot         (out_bot),
    .sat_flag        (sat_flag)
`else
    .out_bot         (out_bot)
`endif
  );

`ifndef PE_SATURATE_EN
  assign sat_flag = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: split operands into lanes as integers, multiply, add the partial sum.
  function automatic void ref_pe(input logic [7:0] x, input logic [7:0] w, input logic [1:0] m,
                                 input logic s, input logic [19:0] top, input logic tv,
                                 output logic [19:0] res, output logic sat);
    int n, l;
    longint acc, xa, wa;
    n = (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 1;
    l = 8 / n;
    acc = 0;
    if (tv) begin
      acc = longint'(top);
      if (s && top[19]) acc -= (longint'(1) << 20);
    end
    for (int i = 0; i < n; i++) begin
      xa = (longint'(x) >> (i * l)) & ((longint'(1) << l) - 1);
      wa = (longint'(w) >> (i * l)) & ((longint'(1) << l) - 1);
      if (s && xa >= (longint'(1) << (l - 1))) xa -= (longint'(1) << l);
      if (s && wa >= (longint'(1) << (l - 1))) wa -= (longint'(1) << l);
      acc += xa * wa;
    end
    sat = 1'b0;
`ifdef PE_SATURATE_EN
    begin
      longint hi, lo;
      hi = s ? 524287 : 1048575;
      lo = s ? -524288 : 0;
      if (acc > hi) begin acc = hi; sat = 1'b1; end
      else if (acc < lo) begin acc = lo; sat = 1'b1; end
    end
`endif
    res = acc[19:0];
  endfunction

  // Apply one cycle of inputs; the model predicts what the next enabled edge produces.
  task automatic drive(input logic e, input logic wl, input logic ws, input logic v,
                       input logic [7:0] x, input logic tv, input logic [19:0] top,
                       input logic [1:0] m, input logic s);
    logic [19:0] res;
    logic        sat;
    @(posedge clk); #1;
    en = e; w_load = wl; w_swap = ws; in_left_valid = v; in_left = x;
    in_top_valid = tv; in_top = top; mode = m; is_signed = s;
    if (e) begin
      right_q.push_back('{v: v, d: x});
      if (v && !wl) begin
        ref_pe(x, m_active, m, s, top, tv, res, sat);
        bot_q.push_back('{v: 1'b1, d: res, sat: sat});
      end else begin
        bot_q.push_back('{v: 1'b0, d: 20'd0, sat: 1'b0});
      end
      if (ws) m_active = m_shadow;
      if (wl) m_shadow = x;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 20'd0, 2'd0, 1'b0);
  endtask

  task automatic load_w(input logic [7:0] w);
    drive(1'b1, 1'b1, 1'b0, 1'b1, w, 1'b0, 20'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 20'd0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    en = 1'b0; w_load = 1'b0; w_swap = 1'b0; in_left_valid = 1'b0; in_top_valid = 1'b0;
    #1;
    check("rst_out_right_valid", 32'(out_right_valid), 32'd0);
    check("rst_out_right", 32'(out_right), 32'd0);
    check("rst_out_bot_valid", 32'(out_bot_valid), 32'd0);
    check("rst_out_bot", 32'(out_bot), 32'd0);
`ifdef PE_SATURATE_EN
    check("rst_sat_flag", 32'(sat_flag), 32'd0);
`endif
    right_q.delete();
    bot_q.delete();
    m_active = '0;
    m_shadow = '0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    // Stage-2 output after the first enabled edge comes from the cleared pipe register.
    bot_q.push_back('{v: 1'b0, d: 20'd0, sat: 1'b0});
  endtask

  always @(posedge clk) begin
    new_edge   <= en && reset;
    stall_edge <= !en && reset;
  end

  // Monitor: one right and one bottom result per enabled edge; frozen outputs on stalled edges.
  always @(negedge clk) begin
    if (reset && new_edge) begin
      if (right_q.size() == 0) begin
        check("right_queue_empty", 32'd1, 32'd0);
      end else begin
        rt_t r;
        r = right_q.pop_front();
        check("out_right_valid", 32'(out_right_valid), 32'(r.v));
        check("out_right", 32'(out_right), 32'(r.d));
      end
      if (bot_q.size() == 0) begin
        check("bot_queue_empty", 32'd1, 32'd0);
      end else begin
        bt_t b;
        b = bot_q.pop_front();
        check("out_bot_valid", 32'(out_bot_valid), 32'(b.v));
        check("out_bot", 32'(out_bot), 32'(b.d));
`ifdef PE_SATURATE_EN
        check("sat_flag", 32'(sat_flag), 32'(b.sat));
`endif
      end
    end else if (reset && stall_edge) begin
      check("stall_right", {23'd0, out_right_valid, out_right}, {23'd0, last_rv, last_r});
      check("stall_bot", {10'd0, sat_flag, out_bot_valid, out_bot}, {10'd0, last_sat, last_bv, last_b});
    end
    last_rv  <= out_right_valid;
    last_r   <= out_right;
    last_bv  <= out_bot_valid;
    last_b   <= out_bot;
    last_sat <= sat_flag;
  end

  initial begin
    do_reset();

    // FULL signed: 7 * -3 + 100
    load_w(8'h07);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFD, 1'b1, 20'd100, 2'd0, 1'b1);
    // QUARTER unsigned then signed with weight 0x55
    load_w(8'h55);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hE4, 1'b1, 20'd0, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hE4, 1'b1, 20'd0, 2'd2, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hB7, 1'b1, 20'd9, 2'd1, 1'b1);

    // Double buffer: swap edge still uses old weight; load+swap same cycle takes old shadow
    load_w(8'h02);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 20'd1, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 20'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h21, 1'b1, 20'd2, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 20'd2, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 20'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 20'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 20'd0, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 20'd0, 2'd0, 1'b0);

    // Stall for 3 cycles mid-stream with weight commands that must be ignored
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h31, 1'b1, 20'd3, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h32, 1'b1, 20'd4, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 20'd7, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 20'd5, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 1'b0, 20'd5, 2'd0, 1'b0);

    // Overflow at the positive signed limit, and the unsigned top of range
    load_w(8'h01);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 20'h7FFFF, 2'd0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 20'hFFFFF, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b1, 20'h80000, 2'd0, 1'b1);

    // Reset with valids in flight; weight must read as zero afterwards
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 20'd6, 2'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h41, 1'b1, 20'd6, 2'd0, 1'b0);
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b1, 20'd5, 2'd0, 1'b1);

    // Random mix of stalls, weight traffic, modes and signedness
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom), 20'($urandom),
            2'($urandom_range(0, 2)), 1'($urandom));
    end

    idle(3);
    @(posedge clk);
    @(negedge clk); #1;
    check("drain_right", 32'(right_q.size()), 32'd0);
    check("drain_bot", 32'(bot_q.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
